// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM states, grant owner and the latency counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      GNT_IF,
      GNT_D
   } grant_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one access at a time.
// Build option MEM_PORT_ARBITER_RR_EN: round-robin on ties; default is data-over-fetch priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 23,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [WIDTH-1:0]  if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [WIDTH-1:0]  d_wdata,
   output logic [WIDTH-1:0]  d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              stall_f,
   output logic              stall_m
);

   arb_state_t       state;
   grant_t           grant;
   grant_t           next_grant;
   logic [CNT_W-1:0] cnt;

`ifdef MEM_PORT_ARBITER_RR_EN
   grant_t           last_grant;
`endif

   // Winner of the next IDLE sample; only meaningful while some request is pending.
   always_comb begin
      next_grant = GNT_IF;
`ifdef MEM_PORT_ARBITER_RR_EN
      if (d_req && if_req)
         next_grant = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
      else if (d_req)
         next_grant = GNT_D;
`else
      if (d_req)
         next_grant = GNT_D;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         grant     <= GNT_IF;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
`ifdef MEM_PORT_ARBITER_RR_EN
         last_grant <= GNT_IF;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  grant  <= next_grant;
                  mem_en <= 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
                  last_grant <= next_grant;
`endif
                  if (next_grant == GNT_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr;
                  end
                  state <= ISSUE;
               end
            end

            // Only the data port can write, so a write always completes on the data side.
            ISSUE: begin
               mem_en <= 1'b0;
               if (mem_we) begin
                  d_ready <= 1'b1;
                  state   <= RESP;
               end else begin
                  cnt   <= CNT_W'(LAT);
                  state <= WAIT;
               end
            end

            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  if (grant == GNT_D) begin
                     d_rdata <= mem_rdata;
                     d_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end
                  state <= RESP;
               end
            end

            RESP: begin
               if_ready <= 1'b0;
               d_ready  <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign stall_f = if_req & ~if_ready;
   assign stall_m = d_req & ~d_ready;

endmodule
